// File: rtl/pipeline_controller.sv
// EX-stage decoder and hazard controller for a small RV32 pipeline.
// Decodes the EX instruction into ALU/branch controls, stalls IF/EX while
// a multi-cycle mul/div occupies EX, registers WB-stage controls and
// forwards the WB result back to the ALU operands.
module pipeline_controller #(
  parameter int ENABLE_M   = 1,
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  output logic [4:0]  aluop,
  output logic        sel_opr_a,
  output logic        sel_opr_b,
  output logic [2:0]  imm_type,
  output logic [2:0]  br_type,
  output logic        sel_pc,
  output logic        stall_o,
  output logic        flush_o,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic        rf_en_wb,
  output logic        rd_en_wb,
  output logic        wr_en_wb,
  output logic [1:0]  sel_wb_wb,
  output logic [2:0]  mem_type_wb,
  output logic [2:0]  csr_op_wb,
  output logic        is_mret_wb,
  output logic        illegal_wb,
  output logic [4:0]  rd_wb
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Counter start value; only used when mul/div actually stalls.
  localparam logic [3:0] CNT_INIT = (MD_LATENCY > 1) ? 4'(MD_LATENCY - 2) : 4'd0;

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign func7  = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  logic       rf_en_next, rd_en_next, wr_en_next, is_mret_next, illegal_next, is_md;
  logic [1:0] sel_wb_next;
  logic [2:0] mem_type_next, csr_op_next;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  // Instruction decode; illegal encodings are collapsed into a bubble at the end.
  always_comb begin
    aluop         = 5'd0;
    sel_opr_a     = 1'b0;
    sel_opr_b     = 1'b0;
    imm_type      = 3'd0;
    br_type       = 3'd0;
    sel_pc        = 1'b0;
    rf_en_next    = 1'b0;
    rd_en_next    = 1'b0;
    wr_en_next    = 1'b0;
    sel_wb_next   = 2'd0;
    mem_type_next = 3'd0;
    csr_op_next   = 3'd0;
    is_mret_next  = 1'b0;
    illegal_next  = 1'b0;
    is_md         = 1'b0;
    case (opcode)
      7'b0110111: begin // LUI
        rf_en_next = 1'b1; sel_opr_b = 1'b1; imm_type = 3'd2; aluop = 5'd10;
      end
      7'b0010111: begin // AUIPC
        rf_en_next = 1'b1; sel_opr_a = 1'b1; sel_opr_b = 1'b1; imm_type = 3'd2;
      end
      7'b1101111: begin // JAL
        rf_en_next = 1'b1; sel_wb_next = 2'd2; sel_opr_a = 1'b1; sel_opr_b = 1'b1;
        imm_type = 3'd1; sel_pc = 1'b1;
      end
      7'b1100111: begin // JALR
        rf_en_next = 1'b1; sel_wb_next = 2'd2; sel_opr_b = 1'b1; sel_pc = 1'b1;
      end
      7'b1100011: begin // branches: target computed as PC + B-imm
        sel_opr_a = 1'b1; sel_opr_b = 1'b1; imm_type = 3'd3; sel_pc = br_taken;
        case (func3)
          3'b000:  br_type = 3'd0;
          3'b001:  br_type = 3'd1;
          3'b100:  br_type = 3'd2;
          3'b101:  br_type = 3'd3;
          3'b110:  br_type = 3'd4;
          3'b111:  br_type = 3'd5;
          default: illegal_next = 1'b1;
        endcase
      end
      7'b0000011: begin // loads
        rf_en_next = 1'b1; rd_en_next = 1'b1; sel_wb_next = 2'd1; sel_opr_b = 1'b1;
        case (func3)
          3'b000:  mem_type_next = 3'd0;
          3'b001:  mem_type_next = 3'd1;
          3'b010:  mem_type_next = 3'd2;
          3'b100:  mem_type_next = 3'd3;
          3'b101:  mem_type_next = 3'd4;
          default: illegal_next  = 1'b1;
        endcase
      end
      7'b0100011: begin // stores
        wr_en_next = 1'b1; sel_opr_b = 1'b1; imm_type = 3'd4; mem_type_next = func3;
        if (func3 > 3'b010) illegal_next = 1'b1;
      end
      7'b0010011, 7'b0110011: begin // OP-IMM and OP share the func3 map
        rf_en_next = 1'b1;
        sel_opr_b  = (opcode == 7'b0010011);
        case (func3)
          3'b000:  aluop = 5'd0;
          3'b001:  aluop = 5'd2;
          3'b010:  aluop = 5'd3;
          3'b011:  aluop = 5'd4;
          3'b100:  aluop = 5'd5;
          3'b101:  aluop = instr[30] ? 5'd7 : 5'd6;
          3'b110:  aluop = 5'd8;
          default: aluop = 5'd9;
        endcase
        if (opcode == 7'b0110011) begin
          if (func7 == 7'b0000001 && ENABLE_M != 0) begin
            is_md = 1'b1;
            aluop = 5'd16 + {2'b00, func3};
          end else if (func7 == 7'b0100000 && func3 == 3'b000) begin
            aluop = 5'd1;
          end else if (!(func7 == 7'b0000000 ||
                         (func7 == 7'b0100000 && func3 == 3'b101))) begin
            illegal_next = 1'b1;
          end
        end
      end
      7'b1110011: begin // SYSTEM: CSR ops and MRET
        csr_op_next = func3;
        if (func3 == 3'b000) begin
          if (instr[31:20] == 12'h302) is_mret_next = 1'b1;
          else                         illegal_next = 1'b1;
        end else if (func3 == 3'b100) begin
          illegal_next = 1'b1;
        end else begin
          rf_en_next = 1'b1; sel_wb_next = 2'd3;
        end
      end
      7'b0001111: ; // FENCE: no-op in this in-order pipeline
      default: illegal_next = 1'b1;
    endcase
    if (illegal_next) begin
      rf_en_next = 1'b0; rd_en_next = 1'b0; wr_en_next = 1'b0;
      sel_pc = 1'b0; is_md = 1'b0; is_mret_next = 1'b0;
    end
  end

  // Mul/div occupancy FSM: first stall cycle is spent in IDLE, the rest in BUSY.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_o    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_md && MD_LATENCY > 1) begin
          stall_o    = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = BUSY;
        end
      end
      default: begin
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
        end else begin
          stall_o  = 1'b1;
          cnt_next = cnt_reg - 4'd1;
        end
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // WB-stage registers: take the decoded instruction, or a bubble while stalled.
  always_ff @(posedge clk) begin
    if (rst || stall_o) begin
      rf_en_wb    <= 1'b0;
      rd_en_wb    <= 1'b0;
      wr_en_wb    <= 1'b0;
      sel_wb_wb   <= 2'd0;
      mem_type_wb <= 3'd0;
      csr_op_wb   <= 3'd0;
      is_mret_wb  <= 1'b0;
      illegal_wb  <= 1'b0;
      rd_wb       <= 5'd0;
    end else begin
      rf_en_wb    <= rf_en_next;
      rd_en_wb    <= rd_en_next;
      wr_en_wb    <= wr_en_next;
      sel_wb_wb   <= sel_wb_next;
      mem_type_wb <= mem_type_next;
      csr_op_wb   <= csr_op_next;
      is_mret_wb  <= is_mret_next;
      illegal_wb  <= illegal_next;
      rd_wb       <= rd;
    end
  end

  assign flush_o = sel_pc & ~stall_o;
  assign fwd_a   = rf_en_wb && (rd_wb != 5'd0) && (rd_wb == rs1);
  assign fwd_b   = rf_en_wb && (rd_wb != 5'd0) && (rd_wb == rs2);

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller (default parameters, MD_LATENCY=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        br_taken;
  logic [4:0]  aluop;
  logic        sel_opr_a, sel_opr_b, sel_pc, stall_o, flush_o, fwd_a, fwd_b;
  logic [2:0]  imm_type, br_type;
  logic        rf_en_wb, rd_en_wb, wr_en_wb, is_mret_wb, illegal_wb;
  logic [1:0]  sel_wb_wb;
  logic [2:0]  mem_type_wb, csr_op_wb;
  logic [4:0]  rd_wb;

  int n_cmp = 0;
  int n_err = 0;
  int n_stall;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADD_I  = 32'h0020_82B3; // add  x5,x1,x2
  localparam logic [31:0] SUB_I  = 32'h4052_8333; // sub  x6,x5,x5
  localparam logic [31:0] MUL_I  = 32'h0220_81B3; // mul  x3,x1,x2
  localparam logic [31:0] DIV_I  = 32'h0220_C3B3; // div  x7,x1,x2
  localparam logic [31:0] BEQ_I  = 32'h0020_8463; // beq  x1,x2,8
  localparam logic [31:0] JAL_I  = 32'h0000_006F; // jal  x0,0
  localparam logic [31:0] CSR_I  = 32'h3000_2273; // csrrs x4,mstatus,x0
  localparam logic [31:0] MRET_I = 32'h3020_0073;
  localparam logic [31:0] BAD_I  = 32'h0000_007F;
  localparam logic [31:0] LHU_I  = 32'h0000_D483; // lhu  x9,0(x1)
  localparam logic [31:0] SRAI_I = 32'h4030_D093; // srai x1,x1,3

  pipeline_controller dut (
    .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken),
    .aluop(aluop), .sel_opr_a(sel_opr_a), .sel_opr_b(sel_opr_b),
    .imm_type(imm_type), .br_type(br_type), .sel_pc(sel_pc),
    .stall_o(stall_o), .flush_o(flush_o), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .rf_en_wb(rf_en_wb), .rd_en_wb(rd_en_wb), .wr_en_wb(wr_en_wb),
    .sel_wb_wb(sel_wb_wb), .mem_type_wb(mem_type_wb), .csr_op_wb(csr_op_wb),
    .is_mret_wb(is_mret_wb), .illegal_wb(illegal_wb), .rd_wb(rd_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic bt);
    instr    = i;
    br_taken = bt;
    #1;
  endtask

  // Advance while stall_o is high (bounded); every WB load during a stall must be a bubble.
  task automatic count_stall(input string tag, output int n);
    n = 0;
    while (stall_o === 1'b1 && n < 20) begin
      n++;
      step();
      check({tag, "_bubble_rf_en"}, 32'(rf_en_wb), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(NOP, 1'b0);
    step();
    step();
    check("rst_rf_en_wb", 32'(rf_en_wb), 32'd0);
    check("rst_rd_wb", 32'(rd_wb), 32'd0);
    check("rst_wb_all", {illegal_wb, is_mret_wb, csr_op_wb, mem_type_wb,
                         sel_wb_wb, wr_en_wb, rd_en_wb}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);

    // Forwarding from WB into both operands
    step();
    drive(ADD_I, 1'b0);
    check("add_aluop", 32'(aluop), 32'd0);
    check("add_fwd_a", 32'(fwd_a), 32'd0);
    step();
    drive(SUB_I, 1'b0);
    check("sub_aluop", 32'(aluop), 32'd1);
    check("sub_rf_en_wb", 32'(rf_en_wb), 32'd1);
    check("sub_rd_wb", 32'(rd_wb), 32'd5);
    check("sub_fwd_a", 32'(fwd_a), 32'd1);
    check("sub_fwd_b", 32'(fwd_b), 32'd1);

    // MUL then DIV back to back: 3 stall cycles each
    step();
    drive(MUL_I, 1'b0);
    check("mul_aluop", 32'(aluop), 32'd16);
    check("mul_stall_first", 32'(stall_o), 32'd1);
    count_stall("mul", n_stall);
    check("mul_stall_cycles", 32'(n_stall), 32'd3);
    step();
    drive(DIV_I, 1'b0);
    check("mul_rd_wb", 32'(rd_wb), 32'd3);
    check("mul_rf_en_wb", 32'(rf_en_wb), 32'd1);
    check("div_aluop", 32'(aluop), 32'd20);
    count_stall("div", n_stall);
    check("div_stall_cycles", 32'(n_stall), 32'd3);
    step();
    drive(NOP, 1'b0);
    check("div_rd_wb", 32'(rd_wb), 32'd7);

    // Branch taken / not taken, and JAL
    drive(BEQ_I, 1'b1);
    check("beq_sel_pc", 32'(sel_pc), 32'd1);
    check("beq_flush", 32'(flush_o), 32'd1);
    check("beq_imm_type", 32'(imm_type), 32'd3);
    check("beq_br_type", 32'(br_type), 32'd0);
    step();
    check("beq_rf_en_wb", 32'(rf_en_wb), 32'd0);
    drive(BEQ_I, 1'b0);
    check("beq_nt_flush", 32'(flush_o), 32'd0);
    check("beq_nt_sel_pc", 32'(sel_pc), 32'd0);
    step();
    drive(JAL_I, 1'b0);
    check("jal_flush", 32'(flush_o), 32'd1);
    check("jal_imm_type", 32'(imm_type), 32'd1);

    // CSR, MRET, illegal opcode
    step();
    drive(CSR_I, 1'b0);
    step();
    drive(MRET_I, 1'b0);
    check("csr_op_wb", 32'(csr_op_wb), 32'd2);
    check("csr_sel_wb_wb", 32'(sel_wb_wb), 32'd3);
    check("csr_rd_wb", 32'(rd_wb), 32'd4);
    check("csr_rf_en_wb", 32'(rf_en_wb), 32'd1);
    step();
    drive(BAD_I, 1'b0);
    check("mret_is_mret_wb", 32'(is_mret_wb), 32'd1);
    check("mret_illegal_wb", 32'(illegal_wb), 32'd0);
    step();
    drive(LHU_I, 1'b0);
    check("bad_illegal_wb", 32'(illegal_wb), 32'd1);
    check("bad_rf_en_wb", 32'(rf_en_wb), 32'd0);
    step();
    drive(SRAI_I, 1'b0);
    check("lhu_mem_type_wb", 32'(mem_type_wb), 32'd4);
    check("lhu_rd_en_wb", 32'(rd_en_wb), 32'd1);
    check("lhu_sel_wb_wb", 32'(sel_wb_wb), 32'd1);
    check("srai_aluop", 32'(aluop), 32'd7);

    // Reset during the second stall cycle of a MUL
    step();
    drive(MUL_I, 1'b0);
    check("mul2_stall_1", 32'(stall_o), 32'd1);
    step();
    check("mul2_stall_2", 32'(stall_o), 32'd1);
    rst = 1'b1;
    drive(NOP, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("midrst_stall", 32'(stall_o), 32'd0);
    check("midrst_state", 32'(dut.state_reg), 32'd0);
    check("midrst_cnt", 32'(dut.cnt_reg), 32'd0);
    check("midrst_rf_en_wb", 32'(rf_en_wb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
